// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush sequencer,
// operand forwarding and memory-busy freeze. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int BR_PENALTY = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_rs1,
  input  logic [3:0]       id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [3:0]       ex_rs1,
  input  logic [3:0]       ex_rs2,
  input  logic [3:0]       ex_rd,
  input  logic             ex_regw,
  input  logic             ex_memr,
  input  logic             ex_branch,
  input  logic             br_taken,
  input  logic [3:0]       mem_rd,
  input  logic             mem_regw,
  input  logic [3:0]       wb_rd,
  input  logic             wb_regw,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic       load_use;
  logic       br_take;

  // Register 15 is the PC: it never forwards and never creates a load-use hazard.
  function automatic logic [1:0] fwd_sel(input logic [3:0] rs,
                                         input logic       m_w,
                                         input logic [3:0] m_rd,
                                         input logic       w_w,
                                         input logic [3:0] w_rd);
    if (m_w && m_rd == rs && m_rd != 4'd15)
      return 2'b10;
    else if (w_w && w_rd == rs && w_rd != 4'd15)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign load_use = ex_memr && ex_regw && (ex_rd != 4'd15) &&
                    ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
  assign br_take  = ex_branch && br_taken;
  assign busy     = (state == FLUSH);

  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    fwd_a    = 2'b00;
    fwd_b    = 2'b00;
    if (!reset) begin
      fwd_a = fwd_sel(ex_rs1, mem_regw, mem_rd, wb_regw, wb_rd);
      fwd_b = fwd_sel(ex_rs2, mem_regw, mem_rd, wb_regw, wb_rd);
      if (mem_busy) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
      end else if (state == FLUSH || br_take) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (load_use) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

  // The resolve cycle is the first flush; FLUSH covers the remaining BR_PENALTY-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else if (!mem_busy) begin
      unique case (state)
        RUN: begin
          if (br_take && BR_PENALTY > 1) begin
            state <= FLUSH;
            cnt   <= 3'(BR_PENALTY - 1);
          end
        end
        FLUSH: begin
          cnt <= cnt - 3'd1;
          if (cnt <= 3'd1)
            state <= RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_id && stall_q != '1)
        stall_q <= stall_q + ONE;
      if (!mem_busy && state == RUN && br_take && flush_q != '1)
        flush_q <= flush_q + ONE;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
